mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arbiter_rr_arbiter2.sv | 44 ++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared definitions for the instruction/data memory arbiter:
//            FSM state encoding, line geometry, default memory latency,
//            requester indices and the line-offset mask.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Cache line width in bits.
  localparam int c_LINE_W      = 128;
  // Default fixed memory latency in cycles (legal range 1..15).
  localparam int c_MEM_LAT_DEF = 5;
  // Byte-offset bits inside one cache line (16-byte line).
  localparam int c_LINE_OFF_W  = 4;
  // Latency counter width; wide enough for MEM_LAT-1 up to 14.
  localparam int c_CNT_W       = 4;

  // Mask of the in-line offset bits; cleared on the memory address.
  localparam logic [31:0] c_OFF_MASK = (32'd1 << c_LINE_OFF_W) - 32'd1;

  // Requester indices into the two-bit request/grant vectors.
  localparam int c_REQ_I = 0;
  localparam int c_REQ_D = 1;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-request round-robin grant. The grant is combinational from
//            the requests and a last-grant register; the register advances
//            only when upd_i is set and some request is present.
// Ports    : clk_i  - clock
//            rsn_i  - synchronous active-low reset
//            req_i  - request vector (bit 0 = instruction, bit 1 = data)
//            upd_i  - record the current grant as the last grant
//            gnt_o  - one-hot grant (all zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rsn_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic [1:0] gnt_o
);

  // 1 = data side was granted last, 0 = instruction side.
  logic r_last_d;

  // On a tie the side not granted last wins; a lone request always wins.
  always_comb begin
    gnt_o          = 2'b00;
    gnt_o[c_REQ_I] = req_i[c_REQ_I] & (~req_i[c_REQ_D] | r_last_d);
    gnt_o[c_REQ_D] = req_i[c_REQ_D] & (~req_i[c_REQ_I] | ~r_last_d);
  end

  // Reset to "data last" so the instruction side wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      r_last_d <= 1'b1;
    end else if (upd_i && (|req_i)) begin
      r_last_d <= gnt_o[c_REQ_D];
    end
  end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one fixed-latency line memory between an instruction
//            refill port and a data read/write-back port. One transaction at
//            a time: IDLE grants, BUSY_x drives memory for MEM_LAT cycles,
//            RESP pulses the owner's ack for one cycle.
// Ports    : clk_i, rsn_i             - clock, synchronous active-low reset
//            ic_req_i/ic_addr_i       - instruction refill request/address
//            ic_abort_i               - cancel pending instruction refill
//            ic_ack_o/ic_line_o       - refill done pulse / line
//            dc_req_i/dc_we_i         - data request / write-back select
//            dc_addr_i/dc_wline_i     - data address / write-back line
//            dc_ack_o/dc_line_o       - data done pulse / read line
//            mem_req_o/mem_we_o       - memory transaction / write enable
//            mem_addr_o/mem_wline_o   - line address / write line
//            mem_rline_i              - read line, valid in last busy cycle
//            busy_o                   - FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = c_MEM_LAT_DEF,
  parameter int LINE_W  = c_LINE_W
)
(
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              ic_req_i,
  input  logic [31:0]       ic_addr_i,
  input  logic              ic_abort_i,
  output logic              ic_ack_o,
  output logic [LINE_W-1:0] ic_line_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [31:0]       dc_addr_i,
  input  logic [LINE_W-1:0] dc_wline_i,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] dc_line_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wline_o,
  input  logic [LINE_W-1:0] mem_rline_i,
  output logic              busy_o
);

  // Counter preload: the last busy cycle is the one where the count is 0.
  localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(MEM_LAT - 1);

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_abort;
  logic [LINE_W-1:0]   r_rline;

  logic [1:0]          w_req;
  logic [1:0]          w_gnt;
  logic                w_arb_upd;
  logic                w_last_busy;

  assign w_req       = {dc_req_i, ic_req_i};
  // Grant history only moves when a grant is actually taken in IDLE.
  assign w_arb_upd   = (r_state == ST_IDLE);
  assign w_last_busy = (r_cnt == '0);

  rr_arbiter2 u_rr_arbiter2 (
    .clk_i (clk_i),
    .rsn_i (rsn_i),
    .req_i (w_req),
    .upd_i (w_arb_upd),
    .gnt_o (w_gnt)
  );

  // Both requesters see the same response register; only the acks differ.
  assign ic_line_o = r_rline;
  assign dc_line_o = r_rline;

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
      r_rline     <= '0;
      ic_ack_o    <= 1'b0;
      dc_ack_o    <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wline_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      ic_ack_o <= 1'b0;
      dc_ack_o <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_gnt[c_REQ_I]) begin
            r_state     <= ST_BUSY_I;
            r_cnt       <= c_CNT_INIT;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= ic_addr_i & ~c_OFF_MASK;
            mem_wline_o <= '0;
            busy_o      <= 1'b1;
          end else if (w_gnt[c_REQ_D]) begin
            r_state     <= ST_BUSY_D;
            r_cnt       <= c_CNT_INIT;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dc_we_i;
            mem_addr_o  <= dc_addr_i & ~c_OFF_MASK;
            mem_wline_o <= dc_wline_i;
            busy_o      <= 1'b1;
          end
        end

        ST_BUSY_I: begin
          if (ic_abort_i) begin
            r_abort <= 1'b1;
          end
          if (w_last_busy) begin
            r_state   <= ST_RESP;
            r_rline   <= mem_rline_i;
            mem_req_o <= 1'b0;
            // An abort seen in the final busy cycle must also suppress ack.
            ic_ack_o  <= ~(r_abort | ic_abort_i);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_BUSY_D: begin
          if (w_last_busy) begin
            r_state   <= ST_RESP;
            if (!mem_we_o) begin
              r_rline <= mem_rline_i;
            end
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            dc_ack_o  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_RESP: begin
          r_state <= ST_IDLE;
          r_abort <= 1'b0;
          busy_o  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter (MEM_LAT = 5).
//            Cycle c means the interval after the c-th rising edge following
//            the cycle in which the request is first presented (cycle 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int LINE_W = 128;

  logic              clk_i = 1'b0;
  logic              rsn_i;
  logic              ic_req_i, ic_abort_i, dc_req_i, dc_we_i;
  logic [31:0]       ic_addr_i, dc_addr_i;
  logic [LINE_W-1:0] dc_wline_i, mem_rline_i;
  logic              ic_ack_o, dc_ack_o, mem_req_o, mem_we_o, busy_o;
  logic [LINE_W-1:0] ic_line_o, dc_line_o, mem_wline_o;
  logic [31:0]       mem_addr_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.MEM_LAT(5), .LINE_W(LINE_W)) dut (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .ic_req_i    (ic_req_i),
    .ic_addr_i   (ic_addr_i),
    .ic_abort_i  (ic_abort_i),
    .ic_ack_o    (ic_ack_o),
    .ic_line_o   (ic_line_o),
    .dc_req_i    (dc_req_i),
    .dc_we_i     (dc_we_i),
    .dc_addr_i   (dc_addr_i),
    .dc_wline_i  (dc_wline_i),
    .dc_ack_o    (dc_ack_o),
    .dc_line_o   (dc_line_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wline_o (mem_wline_o),
    .mem_rline_i (mem_rline_i),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [127:0] pat(input logic [31:0] base, input int c);
    logic [31:0] w;
    w = base + 32'(c);
    return {w, w, w, w};
  endfunction

  task automatic do_reset();
    rsn_i = 1'b0;
    ic_req_i = 1'b0; ic_abort_i = 1'b0; dc_req_i = 1'b0; dc_we_i = 1'b0;
    ic_addr_i = '0; dc_addr_i = '0; dc_wline_i = '0; mem_rline_i = '0;
    repeat (2) tick();
    rsn_i = 1'b1;
  endtask

  logic [127:0] saved_line;

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    chk("rst_busy",  128'(busy_o),    128'(0));
    chk("rst_memreq",128'(mem_req_o), 128'(0));
    chk("rst_ack",   128'({ic_ack_o, dc_ack_o, mem_we_o}), 128'(0));
    chk("rst_addr",  128'(mem_addr_o), 128'(0));
    chk("rst_line",  ic_line_o | dc_line_o | mem_wline_o, 128'(0));

    // ---------------- single instruction refill ----------------
    ic_req_i = 1'b1; ic_addr_i = 32'h0000_1004; mem_rline_i = pat(32'hC0DE_0000, 0);
    for (int c = 1; c <= 7; c++) begin
      tick();
      mem_rline_i = pat(32'hC0DE_0000, c);
      chk($sformatf("i_memreq_c%0d", c), 128'(mem_req_o), 128'(c <= 5));
      chk($sformatf("i_ack_c%0d", c),    128'(ic_ack_o),  128'(c == 6));
      chk($sformatf("i_busy_c%0d", c),   128'(busy_o),    128'(c <= 6));
      if (c <= 5) begin
        chk($sformatf("i_addr_c%0d", c), 128'(mem_addr_o), 128'(32'h0000_1000));
        chk($sformatf("i_we_c%0d", c),   128'(mem_we_o),   128'(0));
      end
      if (c == 6) begin
        chk("i_line", ic_line_o, pat(32'hC0DE_0000, 5));
        ic_req_i = 1'b0;
      end
    end
    saved_line = pat(32'hC0DE_0000, 5);

    // ---------------- data write-back (response register must hold) ----------------
    dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h0000_2010;
    dc_wline_i = {16{8'hA5}};
    for (int c = 1; c <= 7; c++) begin
      tick();
      mem_rline_i = pat(32'hBEEF_0000, c);
      chk($sformatf("w_memreq_c%0d", c), 128'(mem_req_o), 128'(c <= 5));
      chk($sformatf("w_we_c%0d", c),     128'(mem_we_o),  128'(c <= 5));
      chk($sformatf("w_ack_c%0d", c),    128'(dc_ack_o),  128'(c == 6));
      if (c <= 5) begin
        chk($sformatf("w_wline_c%0d", c), mem_wline_o, {16{8'hA5}});
        chk($sformatf("w_addr_c%0d", c),  128'(mem_addr_o), 128'(32'h0000_2010));
      end
      if (c == 6) begin
        chk("w_line_hold", dc_line_o, saved_line);
        dc_req_i = 1'b0; dc_we_i = 1'b0;
      end
    end

    // ---------------- aborted instruction refill ----------------
    ic_req_i = 1'b1; ic_addr_i = 32'h0000_300C;
    for (int c = 1; c <= 8; c++) begin
      tick();
      ic_abort_i = (c == 3);
      if (c == 3) ic_req_i = 1'b0;
      chk($sformatf("a_memreq_c%0d", c), 128'(mem_req_o), 128'(c <= 5));
      chk($sformatf("a_ack_c%0d", c),    128'(ic_ack_o),  128'(0));
      chk($sformatf("a_busy_c%0d", c),   128'(busy_o),    128'(c <= 6));
    end

    // ---------------- simultaneous requests: I,D,I,D round-robin ----------------
    do_reset();
    ic_req_i = 1'b1; ic_addr_i = 32'h0000_0100;
    dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h0000_0200;
    for (int c = 1; c <= 28; c++) begin
      int k, ph;
      tick();
      k  = (c - 1) / 7;
      ph = (c - 1) % 7;
      if (ph == 0)
        chk($sformatf("rr_addr_t%0d", k), 128'(mem_addr_o),
            128'((k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200));
      chk($sformatf("rr_memreq_c%0d", c), 128'(mem_req_o), 128'(ph <= 4));
      chk($sformatf("rr_iack_c%0d", c), 128'(ic_ack_o), 128'(ph == 5 && k % 2 == 0));
      chk($sformatf("rr_dack_c%0d", c), 128'(dc_ack_o), 128'(ph == 5 && k % 2 == 1));
    end
    ic_req_i = 1'b0; dc_req_i = 1'b0;
    tick(); tick();

    // ---------------- reset in the middle of a data read ----------------
    dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h0000_4000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 3) rsn_i = 1'b0;
      if (c == 4) begin
        rsn_i = 1'b1;
        dc_req_i = 1'b0;
      end
      if (c <= 3) chk($sformatf("r_memreq_c%0d", c), 128'(mem_req_o), 128'(1));
      chk($sformatf("r_dack_c%0d", c), 128'(dc_ack_o), 128'(0));
      if (c >= 4) begin
        chk($sformatf("r_ctrl_c%0d", c), 128'({mem_req_o, mem_we_o, busy_o, ic_ack_o}), 128'(0));
        chk($sformatf("r_addr_c%0d", c), 128'(mem_addr_o), 128'(0));
        chk($sformatf("r_line_c%0d", c), dc_line_o | mem_wline_o, 128'(0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    n_errors++;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
